result_bcd: RTL
===============

Name: result_bcd

Overview:
- Downstream stage of the Booth multiplier.
- Captures the signed two's-complement product when the multiplier's `fin` rises.
- Converts the magnitude to packed BCD with a sequential shift-add-3 (double-dabble) loop, then presents sign plus decimal digits to the board display logic.
- Sits between the multiplier's `Result_mul`/`fin` outputs and the display driver.

Parameters:
- WIDTH, 6: product width in bits (signed two's complement), matching the multiplier result.
- DIGITS, 2: number of BCD output digits. Must satisfy 10^DIGITS > 2^(WIDTH-1).

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- Result_mul  input  WIDTH  signed product from the multiplier; sampled only on a fin rising edge.
- fin  input  1  multiplier completion; level or pulse, edge-detected here.
- sign  output  1  1 = negative product.
- bcd  output  4*DIGITS  packed BCD magnitude; digit 0 in [3:0].
- valid  output  1  one-cycle pulse when sign/bcd update.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is asynchronous and active-low. While reset is low:
  - state = IDLE; sign, bcd, valid, busy = 0; internal shift regs = 0.
  - fin_d (the registered fin) = 1, so a fin still high at reset release is never treated as an edge.
- Edge detect: fin_rise = fin & ~fin_d. fin_d <= fin on every clock.
- State machine: IDLE -> CONV -> DONE -> IDLE.
- IDLE:
  - On fin_rise: capture s = Result_mul[WIDTH-1].
  - mag = s ? (~Result_mul + 1) : Result_mul, kept as WIDTH-bit unsigned. Most-negative input (-2^(WIDTH-1)) maps correctly to 2^(WIDTH-1).
  - Clear scratch BCD, cnt = WIDTH, busy <= 1, go to CONV.
- CONV, each cycle:
  - Every scratch digit >= 5 gets +3.
  - Then shift {scratch, mag} left by 1.
  - cnt decrements; when cnt reaches 1 on this cycle (the WIDTH-th shift), go to DONE.
- DONE:
  - sign <= s; bcd <= scratch; valid <= 1 for exactly one cycle.
  - busy <= 0; go to IDLE.
- Latency: with the capture edge = edge 0, valid is high for the cycle following edge WIDTH+1 (7 cycles for the default).
- Output hold: sign and bcd hold their value until the next DONE.
- fin_rise while in CONV or DONE: ignored and not queued. The in-flight conversion completes unchanged.
- fin held high for many cycles: exactly one conversion.
- Reset mid-conversion: immediate return to reset values; the partial result is discarded.
- No overflow path: the parameter constraint guarantees the result fits in DIGITS.

Optional Feature:
- Macro: RESULT_BCD_SEG7_EN.
- When defined, adds two ports:
  - seg, output, 7*DIGITS: active-high segments ordered gfedcba, one group per digit, digit 0 in [6:0].
  - seg_minus, output, 1: equals sign.
- seg is registered and updated in the same cycle as bcd; reset value is 0.
- Codes 0-9 use the standard glyphs; any other code gives blank.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared header booth_defs.vh holds:
  - state encodings IDLE/CONV/DONE (2-bit);
  - default WIDTH/DIGITS;
  - the 7-segment glyph constants.
- One sub-module, bcd_seg7: combinational 4-bit BCD -> 7-segment decoder, instantiated DIGITS times, only under RESULT_BCD_SEG7_EN.

Test Plan:
- Result_mul=6'b001100 (12), fin rise -> busy high for 7 cycles; valid pulse 7 cycles after the capture edge; sign=0, bcd=8'h12.
- Result_mul=6'b110100 (-12) -> sign=1, bcd=8'h12. Then 6'b000000 -> sign=0, bcd=8'h00.
- Boundaries: 6'b100000 (-32) -> sign=1, bcd=8'h32; 6'b011111 (31) -> sign=0, bcd=8'h31.
- fin held high 5 cycles, plus a second fin rise at cycle 3 with Result_mul=6'b000011 -> exactly one valid pulse carrying the first value (bcd=8'h12). A later clean rise converts 3 -> bcd=8'h03.
- reset low at cycle 3 of CONV -> outputs 0 immediately. Release reset with fin still high -> no conversion. Next fin rise converts normally.
- With RESULT_BCD_SEG7_EN defined: Result_mul=6'b010000 (16) -> bcd=8'h16, seg={7'h06,7'h7D}, seg_minus=0.

Source files
------------

// File: rtl/result_bcd_pkg.sv
// result_bcd_pkg: shared definitions for the Booth result display path.
// Holds the FSM state encoding, default product/digit sizing and the
// 7-segment glyph table (active-high, bit order gfedcba).
package result_bcd_pkg;

   localparam int unsigned WIDTH_DEF  = 6;
   localparam int unsigned DIGITS_DEF = 2;
   localparam int unsigned SEG_W      = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/result_bcd_seg7.sv
// bcd_seg7: combinational BCD digit to 7-segment decoder.
// Ports: digit - 4-bit BCD code; seg_c - active-high segments gfedcba.
// Codes above 9 produce a blank glyph.
module bcd_seg7
   import result_bcd_pkg::*;
(
   input  logic [3:0]       digit,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (digit)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/result_bcd.sv
// result_bcd: captures the signed Booth product on a rising edge of fin and
// converts its magnitude to packed BCD with a shift-add-3 loop.
// Optional build macro RESULT_BCD_SEG7_EN adds 7-segment outputs.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   Result_mul - signed product, sampled on a fin rising edge
//   fin        - multiplier completion (level or pulse)
//   sign       - 1 = negative product
//   bcd        - packed BCD magnitude, digit 0 in [3:0]
//   valid      - one-cycle pulse when sign/bcd update
//   busy       - high while a conversion is running
//   seg        - (RESULT_BCD_SEG7_EN) gfedcba per digit, digit 0 in [6:0]
//   seg_minus  - (RESULT_BCD_SEG7_EN) mirrors sign
module result_bcd
   import result_bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned DIGITS = DIGITS_DEF
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      Result_mul,
   input  logic                  fin,
   output logic                  sign,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  valid,
   output logic                  busy
`ifdef RESULT_BCD_SEG7_EN
  ,output logic [SEG_W*DIGITS-1:0] seg,
   output logic                  seg_minus
`endif
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t             state, state_nxt;
   logic               fin_d;
   logic               fin_rise_c;
   logic               s_q;
   logic [WIDTH-1:0]   mag;
   logic [BCD_W-1:0]   scratch;
   logic [BCD_W-1:0]   adj_c;
   logic [CNT_W-1:0]   cnt;
   logic               last_shift_c;

   assign fin_rise_c   = fin & ~fin_d;
   assign last_shift_c = (cnt == CNT_W'(1));

   // Add 3 to every scratch digit >= 5 ahead of the shift.
   always_comb begin
      adj_c = scratch;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj_c[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fin_rise_c)   state_nxt = CONV;
         CONV:    if (last_shift_c) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Edge detector; fin_d resets high so a level still asserted at
   // reset release is not mistaken for a new completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) fin_d <= 1'b1;
      else        fin_d <= fin;
   end

   // Conversion datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_q     <= 1'b0;
         mag     <= '0;
         scratch <= '0;
         cnt     <= '0;
         sign    <= 1'b0;
         bcd     <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (fin_rise_c) begin
                  s_q     <= Result_mul[WIDTH-1];
                  // WIDTH-bit unsigned negate maps -2^(WIDTH-1) onto 2^(WIDTH-1).
                  mag     <= Result_mul[WIDTH-1] ? WIDTH'(~Result_mul + WIDTH'(1))
                                                 : Result_mul;
                  scratch <= '0;
                  cnt     <= CNT_W'(WIDTH);
                  busy    <= 1'b1;
               end
            end
            CONV: begin
               scratch <= {adj_c[BCD_W-2:0], mag[WIDTH-1]};
               mag     <= {mag[WIDTH-2:0], 1'b0};
               cnt     <= cnt - CNT_W'(1);
            end
            DONE: begin
               sign  <= s_q;
               bcd   <= scratch;
               valid <= 1'b1;
               busy  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef RESULT_BCD_SEG7_EN
   logic [SEG_W*DIGITS-1:0] seg_c;

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
      bcd_seg7 u_seg (
         .digit (scratch[4*g +: 4]),
         .seg_c (seg_c[SEG_W*g +: SEG_W])
      );
   end

   // Segment register loads alongside bcd.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              seg <= '0;
      else if (state == DONE)  seg <= seg_c;
   end

   assign seg_minus = sign;
`endif

endmodule
